mux_scan_nto1: RTL and testbench
================================

Name: mux_scan_nto1

Overview:
Parametrised N-channel, W-bit registered multiplexer, replacing fixed-size combinational muxes in data-path selection.
- Direct mode: the channel is chosen by the `sel` input.
- Scan mode: an internal pointer sequences the channels automatically, holding each one for a programmable dwell time.
- Outputs are registered and carry a valid flag, the source channel index and a wrap pulse, for the downstream sampler/serialiser.

Parameters:
N, 8, number of input channels (2..256, need not be a power of 2)
W, 1, bits per channel
SW, $clog2(N), select/channel index width (derived, do not override)
DW, 8, width of dwell input

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  enable; 0 pauses the block
mode  in  1  0 = direct select, 1 = auto-scan
sel  in  SW  channel select in direct mode
dwell  in  DW  extra cycles per channel in scan mode (each channel is held for dwell+1 cycles)
a  in  N*W  packed channel inputs
y  out  W  registered selected channel data
y_valid  out  1  y holds a valid sample this cycle
ch  out  SW  channel index that produced y
wrap  out  1  one-cycle pulse marking the last sample of channel N-1 in scan mode

Behaviour:
- Channel ordering: index k selects a[(N-k)*W-1 -: W], so channel 0 is the most-significant slice.
- Reset (rst_n=0, asynchronous): y=0, y_valid=0, ch=0, wrap=0, scan pointer ptr=0, dwell counter cnt=0. The first update happens on the first clk edge after release.
- Latency: 1 cycle from the input/sel sample to y in both modes.
- en=0:
  - y and ch hold their values.
  - y_valid=0 and wrap=0.
  - ptr and cnt freeze. Scan resumes from the exact point it paused; the remaining dwell is preserved.
- Direct mode (mode=0, en=1):
  - sel<N: y<=slice(sel), ch<=sel, y_valid<=1, wrap<=0.
  - sel>=N (only possible when N is not a power of 2): y<=0, ch holds, y_valid<=0.
  - ptr and cnt are forced to 0 every cycle.
- Scan mode (mode=1, en=1), every cycle:
  - y<=slice(ptr), ch<=ptr, y_valid<=1.
  - If cnt>=dwell (>= so that lowering dwell mid-channel is safe): cnt<=0 and ptr advances. The pointer goes ptr+1, or 0 when ptr==N-1.
  - Otherwise: cnt<=cnt+1, ptr holds.
  - wrap<=1 exactly when ptr==N-1 and cnt>=dwell, so it is aligned with the last y sample of channel N-1.
- Mode switch:
  - 0->1: scan starts at channel 0 with a full dwell, because ptr and cnt were held at 0.
  - 1->0: the next y follows sel; ptr and cnt clear to 0 on that edge.
- dwell is sampled live every cycle. Period per full scan = N*(dwell+1) cycles when dwell is static.
- Width rules:
  - cnt is DW bits wide and never overflows, since it compares against dwell of the same width.
  - dwell=2^DW-1 gives 2^DW cycles per channel.
- Simultaneous en=0 and a mode change: en has priority. Everything freezes and the mode change takes effect on the first en=1 cycle.
- Reset asserted mid-scan or mid-pause: all state returns to the reset values immediately. No residual dwell or pointer state survives.

Test Plan:
1. Reset: N=8, W=4, scan running at ch=5; pull rst_n low between edges -> y=0, y_valid=0, ch=0, wrap=0 without waiting for a clock edge; after release, the first scan sample is ch=0.
2. Direct: N=8, W=4, a=32'h76543210, mode=0, en=1; sel=0 -> next cycle y=4'h7, ch=0, y_valid=1; sel=5 -> y=4'h2, ch=5.
3. Scan with dwell=0, same a: ch sequence 0,1,...,7,0 and y sequence 7,6,...,0,7 on consecutive cycles; wrap=1 only on the ch=7 cycle.
4. Scan with dwell=2: each ch is held for 3 cycles, and wrap pulses once every 24 cycles. Then change dwell to 0 while cnt=2 -> the channel advances on the next edge.
5. Pause: scanning with dwell=3, drop en at ch=3 after 2 cycles for 4 cycles -> y and ch hold, y_valid=0, wrap=0; on en=1, ch=3 persists for exactly 2 more cycles and then goes to 4.
6. N=5, W=2: direct sel=6 -> y=0, y_valid=0, ch unchanged; scan with dwell=0 -> ch sequence 0..4,0 with wrap on ch=4; switch to mode=0 mid-scan, then back to mode=1 -> restarts at ch=0.

Source files
------------

// File: rtl/mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// mux_scan_nto1
//
// N-channel, W-bit registered multiplexer with two selection modes:
//   - direct : the channel is taken from the sel input every cycle
//   - scan   : an internal pointer walks channels 0..N-1, holding each one
//              for dwell+1 cycles, then wraps back to channel 0
// The output sample is registered (1 cycle latency from a/sel to y) and is
// accompanied by a valid flag, the index of the channel that produced it,
// and a one-cycle wrap pulse on the last sample of channel N-1 in scan mode.
//
// Channel k occupies a[(N-k)*W-1 -: W], so channel 0 is the most-significant
// slice of the packed input bus.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      enable; 0 freezes the scan state and holds y/ch
//   mode     in   1      0 = direct select, 1 = auto-scan
//   sel      in   SW     channel select used in direct mode
//   dwell    in   DW     extra cycles per channel in scan mode
//   a        in   N*W    packed channel inputs
//   y        out  W      registered selected channel data
//   y_valid  out  1      y holds a valid sample this cycle
//   ch       out  SW     channel index that produced y
//   wrap     out  1      pulse on the last sample of channel N-1 (scan mode)
// -----------------------------------------------------------------------------
module mux_scan_nto1 #(
   parameter int N  = 8,
   parameter int W  = 1,
   parameter int SW = $clog2(N),
   parameter int DW = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [DW-1:0]  dwell,
   input  logic [N*W-1:0] a,
   output logic [W-1:0]   y,
   output logic           y_valid,
   output logic [SW-1:0]  ch,
   output logic           wrap
);

   // One extra bit so that N itself is representable when N is a power of 2.
   localparam logic [SW:0]   LP_N    = (SW+1)'(N);
   localparam logic [SW-1:0] LP_LAST = SW'(N-1);

   // Scan state
   logic [SW-1:0] r_ptr;
   logic [DW-1:0] r_cnt;

   // Output registers
   logic [W-1:0]  r_y;
   logic          r_y_valid;
   logic [SW-1:0] r_ch;
   logic          r_wrap;

   // Combinational helpers
   logic [SW-1:0] w_idx;
   logic [W-1:0]  w_data;
   logic          w_sel_ok;
   logic          w_dwell_done;
   logic          w_at_last;

   // The pointer only drives the mux in scan mode; in direct mode sel does.
   assign w_idx        = mode ? r_ptr : sel;
   // Only reachable as false when N is not a power of 2.
   assign w_sel_ok     = ({1'b0, sel} < LP_N);
   // >= rather than == so that lowering dwell mid-channel advances at once
   // instead of letting cnt run the full DW-bit range.
   assign w_dwell_done = (r_cnt >= dwell);
   assign w_at_last    = (r_ptr == LP_LAST);

   // N-way mux; an index with no matching channel yields 0.
   always_comb begin
      // NOTE: default assignment first, so every path writes w_data and no
      // latch is inferred when w_idx matches no channel.
      w_data = '0;
      for (int k = 0; k < N; k++) begin
         if (w_idx == SW'(k)) begin
            w_data = a[(N-k)*W-1 -: W];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_ch      <= '0;
         r_wrap    <= 1'b0;
      end else if (!en) begin
         // Paused: y, ch, ptr and cnt hold; pulses are suppressed. A pending
         // mode change waits until en returns.
         r_y_valid <= 1'b0;
         r_wrap    <= 1'b0;
      end else if (!mode) begin
         // Direct select. Scan state is parked at 0 so that entering scan
         // mode always starts at channel 0 with a full dwell.
         r_ptr  <= '0;
         r_cnt  <= '0;
         r_wrap <= 1'b0;
         if (w_sel_ok) begin
            r_y       <= w_data;
            r_ch      <= sel;
            r_y_valid <= 1'b1;
         end else begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
         end
      end else begin
         // Auto-scan: sample the current pointer, then advance or keep dwelling.
         r_y       <= w_data;
         r_ch      <= r_ptr;
         r_y_valid <= 1'b1;
         r_wrap    <= w_at_last && w_dwell_done;
         if (w_dwell_done) begin
            r_cnt <= '0;
            r_ptr <= w_at_last ? '0 : r_ptr + SW'(1);
         end else begin
            r_cnt <= r_cnt + DW'(1);
         end
      end
   end

   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign ch      = r_ch;
   assign wrap    = r_wrap;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_nto1
//
// Self-checking bench for mux_scan_nto1. Two instances are exercised:
//   u_dut8 : N=8, W=4 (power-of-2 channel count)
//   u_dut5 : N=5, W=2 (non-power-of-2, out-of-range select possible)
// Each scenario task pushes the expected registered output to a scoreboard
// queue when it drives a cycle of stimulus, and pops/compares it once the
// DUT has produced that output (1 ns after the next rising edge).
// -----------------------------------------------------------------------------
module tb_mux_scan_nto1;

   typedef struct packed {
      logic [3:0] y;
      logic       v;
      logic [2:0] ch;
      logic       w;
   } obs_t;

   typedef struct {
      bit   en;
      bit   mode;
      int   sel;
      obs_t exp;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // N=8, W=4 instance
   logic        en8, mode8;
   logic [2:0]  sel8;
   logic [7:0]  dwell8;
   logic [31:0] a8;
   logic [3:0]  y8;
   logic        v8, w8;
   logic [2:0]  ch8;

   // N=5, W=2 instance
   logic        en5, mode5;
   logic [2:0]  sel5;
   logic [7:0]  dwell5;
   logic [9:0]  a5;
   logic [1:0]  y5;
   logic        v5, w5;
   logic [2:0]  ch5;

   obs_t sb_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   // Channel values of a5 = 11_10_01_00_11 (channel 0 first).
   int lut5 [5] = '{3, 2, 1, 0, 3};

   mux_scan_nto1 #(.N(8), .W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .mode(mode8), .sel(sel8),
      .dwell(dwell8), .a(a8), .y(y8), .y_valid(v8), .ch(ch8), .wrap(w8)
   );

   mux_scan_nto1 #(.N(5), .W(2)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .sel(sel5),
      .dwell(dwell5), .a(a5), .y(y5), .y_valid(v5), .ch(ch5), .wrap(w5)
   );

   function automatic obs_t mk(int y, bit v, int ch, bit w);
      obs_t o;
      o.y  = 4'(y);
      o.v  = v;
      o.ch = 3'(ch);
      o.w  = w;
      return o;
   endfunction

   function automatic obs_t got8();
      return {y8, v8, ch8, w8};
   endfunction

   function automatic obs_t got5();
      return {2'b00, y5, v5, ch5, w5};
   endfunction

   // ---------------------------------------------------------------------------
   // 1. Reset: idle reset state, then asynchronous reset mid-scan at ch=5.
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      obs_t exp;
      tests_run++;
      if ({got8(), got5()} !== {mk(0, 0, 0, 0), mk(0, 0, 0, 0)})
         begin
            tests_failed++;
            $display("FAIL reset_idle: got dut8=%h dut5=%h want 000 000", got8(), got5());
         end
      rst_n = 1'b1;

      en8 = 1'b1; mode8 = 1'b1; dwell8 = 8'd0; sel8 = 3'd0;
      for (int k = 0; k < 6; k++) begin
         sb_q.push_back(mk(7 - k, 1, k, 0));
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL reset_prescan k=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     k, y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end

      // Scan now sits at ch=5; assert reset between edges and look at once.
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({got8(), got5()} !== {mk(0, 0, 0, 0), mk(0, 0, 0, 0)}) begin
         tests_failed++;
         $display("FAIL reset_async: got dut8=%h dut5=%h want 000 000", got8(), got5());
      end
      #1 rst_n = 1'b1;

      sb_q.push_back(mk(7, 1, 0, 0));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      tests_run++;
      if (got8() !== exp) begin
         tests_failed++;
         $display("FAIL reset_first_scan: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                  y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
      end
   endtask

   // ---------------------------------------------------------------------------
   // 2. Direct select.
   // ---------------------------------------------------------------------------
   task automatic test_direct();
      obs_t exp;
      int   sels [5] = '{0, 5, 3, 7, 1};
      en8 = 1'b1; mode8 = 1'b0;
      foreach (sels[i]) begin
         sel8 = 3'(sels[i]);
         sb_q.push_back(mk(7 - sels[i], 1, sels[i], 0));
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL direct sel=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     sels[i], y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // 3. Scan with dwell=0: one channel per cycle, wrap on ch=7.
   // ---------------------------------------------------------------------------
   task automatic test_scan_dwell0();
      obs_t exp;
      mode8 = 1'b1; dwell8 = 8'd0;
      for (int k = 0; k < 10; k++) begin
         sb_q.push_back(mk(7 - (k % 8), 1, k % 8, (k % 8) == 7));
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL scan_dwell0 k=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     k, y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // 4. Scan with dwell=2 (24-cycle period), then live dwell changes.
   // ---------------------------------------------------------------------------
   task automatic test_scan_dwell();
      obs_t exp;
      int   nwrap = 0;
      int   ch;
      int   dws [12] = '{2, 2, 0, 0, 0, 5, 5, 5, 1, 1, 1, 1};
      int   chs [12] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 4, 5};

      // One direct cycle parks the scan state at ptr=0, cnt=0.
      mode8 = 1'b0; sel8 = 3'd0;
      sb_q.push_back(mk(7, 1, 0, 0));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      tests_run++;
      if (got8() !== exp) begin
         tests_failed++;
         $display("FAIL dwell_park: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                  y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
      end

      mode8 = 1'b1; dwell8 = 8'd2;
      for (int i = 0; i < 48; i++) begin
         ch = (i / 3) % 8;
         sb_q.push_back(mk(7 - ch, 1, ch, (ch == 7) && (i % 3 == 2)));
         @(posedge clk); #1;
         if (w8 === 1'b1) nwrap++;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL scan_dwell2 i=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     i, y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end
      tests_run++;
      if (nwrap !== 2) begin
         tests_failed++;
         $display("FAIL wrap_count: got %0d pulses in 48 cycles want 2", nwrap);
      end

      // Lower dwell while a channel is partway through its dwell.
      foreach (dws[i]) begin
         dwell8 = 8'(dws[i]);
         sb_q.push_back(mk(7 - chs[i], 1, chs[i], 0));
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL dwell_change i=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     i, y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // 5. Pause: dwell=3, drop en 2 cycles into ch=3 for 4 cycles, then resume.
   // ---------------------------------------------------------------------------
   task automatic test_pause();
      obs_t  exp;
      stim_t tbl[$];
      stim_t s;

      s.en = 1; s.mode = 0; s.sel = 0; s.exp = mk(7, 1, 0, 0); tbl.push_back(s);
      for (int i = 0; i < 14; i++) begin
         s.en = 1; s.mode = 1; s.sel = 0; s.exp = mk(7 - i / 4, 1, i / 4, 0);
         tbl.push_back(s);
      end
      for (int i = 0; i < 4; i++) begin
         s.en = 0; s.mode = 1; s.sel = 0; s.exp = mk(4, 0, 3, 0); tbl.push_back(s);
      end
      s.en = 1; s.mode = 1; s.sel = 0; s.exp = mk(4, 1, 3, 0); tbl.push_back(s);
      s.exp = mk(4, 1, 3, 0); tbl.push_back(s);
      s.exp = mk(3, 1, 4, 0); tbl.push_back(s);

      dwell8 = 8'd3;
      foreach (tbl[i]) begin
         en8 = tbl[i].en; mode8 = tbl[i].mode; sel8 = 3'(tbl[i].sel);
         sb_q.push_back(tbl[i].exp);
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got8() !== exp) begin
            tests_failed++;
            $display("FAIL pause step=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     i, y8, v8, ch8, w8, exp.y, exp.v, exp.ch, exp.w);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // 6. N=5: out-of-range select, scan/wrap, mode switches, en priority.
   // ---------------------------------------------------------------------------
   task automatic test_n5();
      obs_t  exp;
      stim_t tbl[$];
      stim_t s;
      int    ch;

      en8 = 1'b0;
      s.en = 1; s.mode = 0;
      s.sel = 2; s.exp = mk(1, 1, 2, 0); tbl.push_back(s);
      s.sel = 6; s.exp = mk(0, 0, 2, 0); tbl.push_back(s);
      s.sel = 5; s.exp = mk(0, 0, 2, 0); tbl.push_back(s);
      s.sel = 4; s.exp = mk(3, 1, 4, 0); tbl.push_back(s);
      for (int k = 0; k < 8; k++) begin
         ch = k % 5;
         s.en = 1; s.mode = 1; s.sel = 0; s.exp = mk(lut5[ch], 1, ch, ch == 4);
         tbl.push_back(s);
      end
      // Mid-scan (ptr=3) switch to direct, then a frozen mode change.
      s.en = 1; s.mode = 0; s.sel = 1; s.exp = mk(2, 1, 1, 0); tbl.push_back(s);
      s.en = 0; s.mode = 1; s.sel = 1; s.exp = mk(2, 0, 1, 0); tbl.push_back(s);
      tbl.push_back(s);
      for (int k = 0; k < 3; k++) begin
         s.en = 1; s.mode = 1; s.sel = 1; s.exp = mk(lut5[k], 1, k, 0);
         tbl.push_back(s);
      end

      a5 = 10'b11_10_01_00_11; dwell5 = 8'd0;
      foreach (tbl[i]) begin
         en5 = tbl[i].en; mode5 = tbl[i].mode; sel5 = 3'(tbl[i].sel);
         sb_q.push_back(tbl[i].exp);
         @(posedge clk); #1;
         exp = sb_q.pop_front();
         tests_run++;
         if (got5() !== exp) begin
            tests_failed++;
            $display("FAIL n5 step=%0d: got y=%h v=%b ch=%0d w=%b want y=%h v=%b ch=%0d w=%b",
                     i, y5, v5, ch5, w5, exp.y, exp.v, exp.ch, exp.w);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      en8 = 1'b0; mode8 = 1'b0; sel8 = '0; dwell8 = '0; a8 = 32'h7654_3210;
      en5 = 1'b0; mode5 = 1'b0; sel5 = '0; dwell5 = '0; a5 = '0;
      #13;

      test_reset();
      test_direct();
      test_scan_dwell0();
      test_scan_dwell();
      test_pause();
      test_n5();

      tests_run++;
      if (sb_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
